uart_tx_retrans_ctrl: RTL

Transmit-side controller for the even-parity UART link with retransmission. It arbitrates between two local requesters that share one serial line, and serializes the granted 7-bit word as a 10-bit frame at one bit per clock. It then waits for the far-end receiver's `ack` or resend request and retransmits on resend request or timeout, up to a bounded retry count. It is the sender-side counterpart of the receiver/retransmit path and drives that path's `signal` input.

---
 rtl/uart_tx_retrans_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/uart_tx_retrans_ctrl.sv
// uart_tx_retrans_ctrl: two-requester even-parity UART frame sender with retries.
// Define UART_TX_RR_EN for round-robin arbitration; fixed priority otherwise.
module uart_tx_retrans_ctrl #(
  parameter int TIMEOUT     = 10,
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [6:0] data0,
  input  logic [6:0] data1,
  input  logic       ack,
  input  logic       nack,
  output logic       signal,
  output logic [1:0] grant,
  output logic       busy,
  output logic [1:0] done,
  output logic [1:0] fail,
  output logic [4:0] resend_count
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] FAIL = 3'd4;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]    state;
  logic [6:0]    payload;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          win;
  logic [9:0]    frame;
  logic          timeout_hit;
  logic          can_retry;

  // frame[0] is the start bit, frame[9] the stop bit
  assign frame       = {1'b1, ^payload, payload, 1'b0};
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign can_retry   = (resend_count < 5'(MAX_RETRIES));
  assign busy        = (state != IDLE);
  assign done        = (state == DONE) ? grant : 2'b00;
  assign fail        = (state == FAIL) ? grant : 2'b00;

`ifdef UART_TX_RR_EN
  logic last;

  always_comb begin
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      last <= 1'b1;
    else if (state == IDLE && req != 2'b00)
      last <= win;
  end
`else
  assign win = ~req[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      signal       <= 1'b1;
      grant        <= 2'b00;
      payload      <= 7'd0;
      bit_cnt      <= 4'd0;
      timer        <= '0;
      resend_count <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state        <= SEND;
            payload      <= win ? data1 : data0;
            grant        <= win ? 2'b10 : 2'b01;
            resend_count <= 5'd0;
            bit_cnt      <= 4'd0;
            signal       <= 1'b0;
          end
        end
        SEND: begin
          if (bit_cnt == 4'd9) begin
            state  <= WAIT;
            timer  <= '0;
            signal <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            signal  <= frame[bit_cnt + 4'd1];
          end
        end
        WAIT: begin
          if (ack) begin
            state <= DONE;
          end else if (nack || timeout_hit) begin
            if (can_retry) begin
              resend_count <= resend_count + 5'd1;
              bit_cnt      <= 4'd0;
              signal       <= 1'b0;
              state        <= SEND;
            end else begin
              state <= FAIL;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE, FAIL: begin
          state <= IDLE;
          grant <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
